// File: rtl/sram_pixel_writer.sv
// sram_pixel_writer
//   Receives pixel writes from the copy engine, clips them to the visible
//   screen, maps them to a linear framebuffer address in the back buffer and
//   queues them in a FIFO. The FIFO drains into the SRAM controller's write
//   slots.
//
//   Ports:
//     clk, reset          system clock, asynchronous active-high reset
//     program_x/y/data    pixel column, row and RGB565 colour
//     program_write       one-cycle write strobe
//     current_frame       displayed frame; writes target ~current_frame
//     program_ready       FIFO can accept a write this cycle
//     wr_slot             controller write slot available this cycle
//     wr_valid            head entry valid
//     wr_addr, wr_data    head entry {frame, y*H_PIXELS+x} and pixel
//     level               current FIFO occupancy
//     overflow            sticky: a write was dropped on a full FIFO
//     drop_count          saturating count of dropped writes
//
//   Build option: define PIXEL_TRANSPARENT_EN to discard pixels whose colour
//   equals TRANSPARENT (colour-key transparency).
module sram_pixel_writer #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned H_PIXELS    = 640,
  parameter int unsigned V_PIXELS    = 480,
  parameter int unsigned ADDR_W      = 20,
  parameter logic [15:0] TRANSPARENT = 16'h0000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [9:0]                      program_x,
  input  logic [9:0]                      program_y,
  input  logic [15:0]                     program_data,
  input  logic                            program_write,
  input  logic                            current_frame,
  output logic                            program_ready,
  input  logic                            wr_slot,
  output logic                            wr_valid,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic [15:0]                     wr_data,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            overflow,
  output logic [7:0]                      drop_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned OFF_W = 19;
  localparam int unsigned ENT_W = 1 + OFF_W + 16;
  localparam logic [9:0]  X_LIM = 10'(H_PIXELS);
  localparam logic [9:0]  Y_LIM = 10'(V_PIXELS);

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OFF_W-1:0] offset;
  logic [ENT_W-1:0] entry_in;
  logic [ENT_W-1:0] head;
  logic             on_screen;
  logic             keep;
  logic             full;
  logic             wr_fire;
  logic             push;
  logic             drop;

  assign on_screen = (program_x < X_LIM) && (program_y < Y_LIM);

`ifdef PIXEL_TRANSPARENT_EN
  assign keep = on_screen && (program_data != TRANSPARENT);
`else
  logic unused_transparent;
  assign unused_transparent = ^TRANSPARENT;
  assign keep = on_screen;
`endif

  assign offset   = OFF_W'(program_y) * OFF_W'(H_PIXELS) + OFF_W'(program_x);
  assign entry_in = {~current_frame, offset, program_data};

  assign full          = (level == LVL_W'(FIFO_DEPTH));
  assign wr_valid      = (level != '0);
  assign wr_fire       = wr_valid & wr_slot;
  assign program_ready = ~full | wr_fire;
  assign push          = program_write & keep & program_ready;
  assign drop          = program_write & keep & ~program_ready;

  // Storage has no reset; outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  assign head = mem[rd_ptr];

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    if (wr_valid) begin
      wr_addr[OFF_W-1:0] = head[16 +: OFF_W];
      wr_addr[ADDR_W-1]  = head[ENT_W-1];
      wr_data            = head[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (wr_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, wr_fire})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_pixel_writer.sv
module tb_sram_pixel_writer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  program_x;
  logic [9:0]  program_y;
  logic [15:0] program_data;
  logic        program_write;
  logic        current_frame;
  logic        program_ready;
  logic        wr_slot;
  logic        wr_valid;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  sram_pixel_writer #(
    .FIFO_DEPTH (DEPTH),
    .H_PIXELS   (640),
    .V_PIXELS   (480),
    .ADDR_W     (20),
    .TRANSPARENT(16'h0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .program_x    (program_x),
    .program_y    (program_y),
    .program_data (program_data),
    .program_write(program_write),
    .current_frame(current_frame),
    .program_ready(program_ready),
    .wr_slot      (wr_slot),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .level        (level),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
  } pix_t;

  pix_t q[$];
  bit   m_ovf;
  int   m_drops;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("wr_valid", 64'(wr_valid), 64'(q.size() > 0));
    check("level", 64'(level), 64'(q.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("drop_count", 64'(drop_count), 64'(m_drops));
    if (q.size() > 0) begin
      check("wr_addr", 64'(wr_addr), 64'(q[0].addr));
      check("wr_data", 64'(wr_data), 64'(q[0].data));
    end else begin
      check("wr_addr_idle", 64'(wr_addr), 64'd0);
      check("wr_data_idle", 64'(wr_data), 64'd0);
    end
  endtask

  // Called just after a rising edge: drive one cycle, predict, step, compare.
  task automatic cycle(input int x, input int y, input logic [15:0] d,
                       input bit w, input bit cf, input bit slot);
    bit full, fire, keep;
    program_x     = 10'(x);
    program_y     = 10'(y);
    program_data  = d;
    program_write = w;
    current_frame = cf;
    wr_slot       = slot;
    #1;
    full = (q.size() == DEPTH);
    fire = (q.size() > 0) && slot;
    check("program_ready", 64'(program_ready), 64'(!full || fire));
    keep = w && (x < 640) && (y < 480);
`ifdef PIXEL_TRANSPARENT_EN
    keep = keep && (d != 16'h0000);
`endif
    if (fire) void'(q.pop_front());
    if (keep) begin
      if (full && !fire) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end else begin
        q.push_back('{addr: 20'((cf ? 0 : 1) * 524288 + y * 640 + x), data: d});
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    program_write = 1'b0;
    wr_slot = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_drops = 0;
    check_outputs();
    check("ready_after_reset", 64'(program_ready), 64'd1);
    reset = 1'b0;
  endtask

  initial begin
    int pct;
    bit cf;
    reset = 1'b0;
    program_x = '0;
    program_y = '0;
    program_data = '0;
    program_write = 1'b0;
    current_frame = 1'b0;
    wr_slot = 1'b0;
    #2;
    reset_dut();

    // Single pixel into back buffer 1, popped on the next edge.
    cycle(5, 2, 16'hABCD, 1, 0, 1);
    check("t1_addr", 64'(wr_addr), 64'h80505);
    check("t1_data", 64'(wr_data), 64'hABCD);
    cycle(0, 0, 16'h0, 0, 0, 1);

    // Fill, overflow by one, then drain in order.
    for (int i = 0; i < 17; i++) cycle(i, 1, 16'(16'h100 + i), 1, 0, 0);
    check("t2_level", 64'(level), 64'd16);
    check("t2_ovf", 64'(overflow), 64'd1);
    check("t2_drops", 64'(drop_count), 64'd1);
    for (int i = 0; i < 16; i++) cycle(0, 0, 16'h0, 0, 0, 1);
    check("t2_drained", 64'(level), 64'd0);

    // Clipping boundaries.
    reset_dut();
    cycle(640, 0, 16'h1234, 1, 0, 0);
    cycle(0, 480, 16'h1234, 1, 0, 0);
    check("t3_clip_level", 64'(level), 64'd0);
    check("t3_clip_ovf", 64'(overflow), 64'd0);
    cycle(639, 479, 16'h5555, 1, 1, 0);
    check("t3_max_offset", 64'(wr_addr[18:0]), 64'd307199);
    cycle(0, 0, 16'h0, 0, 0, 1);

    // Push + pop on a full FIFO is accepted.
    for (int i = 0; i < 16; i++) cycle(i * 3, 7, 16'(16'h200 + i), 1, 0, 0);
    cycle(100, 100, 16'hBEEF, 1, 0, 1);
    check("t4_level", 64'(level), 64'd16);
    check("t4_drops", 64'(drop_count), 64'd0);

    // Drop counter saturates.
    for (int i = 0; i < 260; i++) cycle(1, 1, 16'h7, 1, 0, 0);
    check("t4_sat", 64'(drop_count), 64'd255);

    // Frame bit is latched per entry; reset mid-drain empties the FIFO.
    reset_dut();
    for (int i = 0; i < 3; i++) cycle(10 + i, 20, 16'(16'h300 + i), 1, 0, 0);
    cycle(13, 20, 16'h303, 1, 1, 0);
    cycle(0, 0, 16'h0, 0, 1, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_valid", 64'(wr_valid), 64'd0);
    check("t5_rst_level", 64'(level), 64'd0);
    q.delete();
    m_ovf = 1'b0;
    m_drops = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Colour-key pixel: queued or discarded depending on the build.
    cycle(4, 4, 16'h0000, 1, 0, 0);
    cycle(0, 0, 16'h0, 0, 0, 1);

    // Randomised traffic with varying slot availability.
    cf = 1'b0;
    pct = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: pct = 15;
          1: pct = 55;
          default: pct = 95;
        endcase
      end
      if ($urandom_range(0, 99) < 3) cf = ~cf;
      if (n % 1000 == 999) reset_dut();
      else
        cycle(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
              ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
              $urandom_range(0, 99) < 70, cf, $urandom_range(0, 99) < pct);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
